// File: rtl/irq_cond_pkg.sv
// irq_cond_pkg: shared constants for the interrupt conditioner.
// Config select codes, the "no interrupt" ID and filter counter sizing.
package irq_cond_pkg;

   localparam logic [1:0] CFG_SEL_MODE = 2'd0;
   localparam logic [1:0] CFG_SEL_POL  = 2'd1;
   localparam logic [1:0] CFG_SEL_EN   = 2'd2;
   localparam logic [1:0] CFG_SEL_OVF  = 2'd3;

   localparam int NUM_IRQ_MAX = 32;

   localparam logic [5:0] ID_NONE = 6'h3F;

   // Counter only has to reach filt_cycles-1 before the toggle.
   function automatic int filt_w(input int filt_cycles);
      return (filt_cycles < 2) ? 1 : $clog2(filt_cycles);
   endfunction

endpackage

// File: rtl/irq_line_filter.sv
// irq_line_filter: one line's synchroniser, polarity XOR and glitch filter.
// Ports: clk, reset (sync, active-high), raw (async in), pol, filt (out).
module irq_line_filter
   import irq_cond_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic pol,
   output logic filt
);

   localparam int CW = filt_w(FILT_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   asrt;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw};
   end

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign asrt = sync_q[SYNC_STAGES-1] ^ pol;

   if (FILT_CYCLES == 0) begin : g_bypass
      logic filt_q;
      logic filt_d;

      always_comb begin
         filt_d = asrt;
      end

      always_ff @(posedge clk) begin
         if (reset) filt_q <= 1'b0;
         else       filt_q <= filt_d;
      end

      assign filt = filt_q;
   end else begin : g_filt
      localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          filt_q;
      logic          filt_d;

      // Count consecutive disagreements; toggle on the last one.
      always_comb begin
         filt_d = filt_q;
         cnt_d  = '0;
         if (asrt != filt_q) begin
            if (cnt_q == CNT_LAST) filt_d = ~filt_q;
            else                   cnt_d  = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
         end
      end

      assign filt = filt_q;
   end

endmodule

// File: rtl/irq_conditioner.sv
// irq_conditioner: conditions raw interrupt lines for the PIC irq bus.
// Ports: clk, reset, irq_raw, cfg_we/sel/wdata, int_ack, ack_id,
//        irq (to PIC), pend (status), ovf (sticky edge overflow).
module irq_conditioner
   import irq_cond_pkg::*;
#(
   parameter int NUM_IRQ     = 32,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_raw,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_sel,
   input  logic [31:0]        cfg_wdata,
   input  logic               int_ack,
   input  logic [5:0]         ack_id,
   output logic [NUM_IRQ-1:0] irq,
   output logic [NUM_IRQ-1:0] pend,
   output logic [NUM_IRQ-1:0] ovf
);

   logic [NUM_IRQ-1:0] filt;
   logic [NUM_IRQ-1:0] prev_q;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   logic [NUM_IRQ-1:0] pol_q, pol_d;
   logic [NUM_IRQ-1:0] en_q, en_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] ovf_q, ovf_d;
   logic [NUM_IRQ-1:0] ovf_w1c;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] ack_vec;
   logic [NUM_IRQ-1:0] mode_chg;
   logic [NUM_IRQ-1:0] ovf_set;
   logic [NUM_IRQ-1:0] edge_p;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
      irq_line_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_CYCLES (FILT_CYCLES)
      ) u_filt (
         .clk   (clk),
         .reset (reset),
         .raw   (irq_raw[g]),
         .pol   (pol_q[g]),
         .filt  (filt[g])
      );
   end

   always_comb begin
      mode_d  = mode_q;
      pol_d   = pol_q;
      en_d    = en_q;
      ovf_w1c = '0;
      if (cfg_we) begin
         unique case (cfg_sel)
            CFG_SEL_MODE: mode_d  = cfg_wdata[NUM_IRQ-1:0];
            CFG_SEL_POL:  pol_d   = cfg_wdata[NUM_IRQ-1:0];
            CFG_SEL_EN:   en_d    = cfg_wdata[NUM_IRQ-1:0];
            CFG_SEL_OVF:  ovf_w1c = cfg_wdata[NUM_IRQ-1:0];
         endcase
      end

      // IDs at or above NUM_IRQ never match any line.
      for (int i = 0; i < NUM_IRQ; i++)
         ack_vec[i] = int_ack && (ack_id == 6'(i));

      rise     = filt & ~prev_q;
      mode_chg = mode_d ^ mode_q;

      // Set beats a coinciding ack.
      edge_p = rise | (pend_q & ~ack_vec);
      pend_d = (mode_q & edge_p) | (~mode_q & filt);

      // Lines changing mode: edge starts empty, level reloads.
      pend_d = (pend_d & ~mode_chg)
             | (mode_chg & ~mode_d & filt);
      pend_d = pend_d & en_q;

      ovf_set = rise & pend_q & ~ack_vec
              & mode_q & en_q & ~mode_chg;
      ovf_d   = (ovf_q & ~ovf_w1c) | ovf_set;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
         mode_q <= '0;
         pol_q  <= '0;
         en_q   <= '0;
         pend_q <= '0;
         ovf_q  <= '0;
      end else begin
         prev_q <= filt;
         mode_q <= mode_d;
         pol_q  <= pol_d;
         en_q   <= en_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign irq  = pend_q & en_q;
   assign pend = pend_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// tb_irq_conditioner: table vectors, directed corner sequences and
// randomized traffic checked against a per-line behavioural model.
module tb_irq_conditioner;
   import irq_cond_pkg::*;

   localparam int N    = 32;
   localparam int SYNC = 2;
   localparam int FILT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] irq_raw = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_sel = '0;
   logic [31:0] cfg_wdata = '0;
   logic        int_ack = 1'b0;
   logic [5:0]  ack_id = ID_NONE;
   logic [31:0] irq;
   logic [31:0] pend;
   logic [31:0] ovf;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   irq_conditioner #(
      .NUM_IRQ     (N),
      .SYNC_STAGES (SYNC),
      .FILT_CYCLES (FILT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_raw   (irq_raw),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_wdata (cfg_wdata),
      .int_ack   (int_ack),
      .ack_id    (ack_id),
      .irq       (irq),
      .pend      (pend),
      .ovf       (ovf)
   );

   // Reference model state
   logic [31:0] m_sync[$];
   logic [31:0] m_hist[$];
   logic [31:0] m_filt = '0, m_prev = '0, m_pend = '0, m_ovf = '0;
   logic [31:0] m_mode = '0, m_pol = '0, m_en = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic model_step();
      logic [31:0] asrt, nfilt, nmode, npol, nen, npend, novf, w1c;
      bit          diff, rise, acked;
      if (reset) begin
         m_sync = {}; m_hist = {};
         repeat (SYNC) m_sync.push_back('0);
         repeat (FILT) m_hist.push_back('0);
         m_filt = '0; m_prev = '0; m_pend = '0; m_ovf = '0;
         m_mode = '0; m_pol = '0; m_en = '0;
         return;
      end
      // Filter: flips once the last FILT samples all disagree.
      asrt = m_sync[SYNC-1] ^ m_pol;
      m_hist.push_front(asrt);
      void'(m_hist.pop_back());
      for (int i = 0; i < N; i++) begin
         diff = 1;
         foreach (m_hist[k]) if (m_hist[k][i] == m_filt[i]) diff = 0;
         nfilt[i] = diff ? ~m_filt[i] : m_filt[i];
      end
      nmode = m_mode; npol = m_pol; nen = m_en; w1c = '0;
      if (cfg_we) begin
         case (cfg_sel)
            CFG_SEL_MODE: nmode = cfg_wdata;
            CFG_SEL_POL:  npol  = cfg_wdata;
            CFG_SEL_EN:   nen   = cfg_wdata;
            default:      w1c   = cfg_wdata;
         endcase
      end
      npend = m_pend;
      novf  = m_ovf & ~w1c;
      for (int i = 0; i < N; i++) begin
         rise  = m_filt[i] && !m_prev[i];
         acked = int_ack && (ack_id == 6'(i));
         if (!m_en[i]) npend[i] = 0;
         else if (nmode[i] != m_mode[i]) npend[i] = nmode[i] ? 1'b0 : m_filt[i];
         else if (!m_mode[i]) npend[i] = m_filt[i];
         else if (rise) begin
            if (m_pend[i] && !acked) novf[i] = 1;
            npend[i] = 1;
         end else if (acked) npend[i] = 0;
      end
      m_sync.push_front(irq_raw);
      void'(m_sync.pop_back());
      m_prev = m_filt; m_filt = nfilt;
      m_mode = nmode; m_pol = npol; m_en = nen;
      m_pend = npend; m_ovf = novf;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("model_irq", irq, m_pend & m_en);
      chk("model_pend", pend, m_pend);
      chk("model_ovf", ovf, m_ovf);
   endtask

   task automatic cfg(input logic [1:0] sel, input logic [31:0] d);
      cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = d;
      tick();
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic ack(input logic [5:0] id);
      int_ack = 1'b1; ack_id = id;
      tick();
      int_ack = 1'b0; ack_id = ID_NONE;
   endtask

   typedef struct {
      logic [31:0] raw;
      logic [31:0] exp_irq;
   } vec_t;

   vec_t vecs[$];

   initial begin
      // Level-path table on line 0: rise, fall, 1-cycle glitch.
      for (int k = 0; k < 10; k++) vecs.push_back('{32'h1, (k >= 5) ? 32'h1 : 32'h0});
      for (int k = 0; k < 10; k++) vecs.push_back('{32'h0, (k < 5) ? 32'h1 : 32'h0});
      vecs.push_back('{32'h1, 32'h0});
      for (int k = 0; k < 9; k++) vecs.push_back('{32'h0, 32'h0});

      // Reset with all lines high
      reset = 1'b1; irq_raw = 32'hFFFF_FFFF;
      tick(); tick();
      chk("rst_irq", irq, 32'h0);
      chk("rst_pend", pend, 32'h0);
      chk("rst_ovf", ovf, 32'h0);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("rst_en0_irq", irq, 32'h0);
      end
      irq_raw = '0;
      repeat (12) tick();

      // Level path
      cfg(CFG_SEL_EN, 32'h1);
      foreach (vecs[v]) begin
         irq_raw = vecs[v].raw;
         tick();
         chk($sformatf("level_vec%0d", v), irq, vecs[v].exp_irq);
      end

      // Edge trigger and ack on line 5
      cfg(CFG_SEL_EN, 32'h21);
      cfg(CFG_SEL_MODE, 32'h20);
      irq_raw[5] = 1'b1;
      repeat (5) tick();
      chk("edge_lat_pre", irq & 32'h20, 32'h0);
      tick();
      chk("edge_lat", irq & 32'h20, 32'h20);
      repeat (4) tick();
      irq_raw[5] = 1'b0;
      repeat (10) tick();
      chk("edge_hold", irq & 32'h20, 32'h20);
      ack(ID_NONE);
      chk("ack_none", irq & 32'h20, 32'h20);
      ack(6'd5);
      chk("ack5", irq & 32'h20, 32'h0);

      // Overflow on line 7
      cfg(CFG_SEL_EN, 32'hA1);
      cfg(CFG_SEL_MODE, 32'hA0);
      for (int p = 0; p < 2; p++) begin
         irq_raw[7] = 1'b1; repeat (8) tick();
         irq_raw[7] = 1'b0; repeat (8) tick();
      end
      chk("ovf_set", ovf & 32'h80, 32'h80);
      chk("ovf_pend", pend & 32'h80, 32'h80);
      cfg(CFG_SEL_OVF, 32'h80);
      chk("ovf_w1c", ovf & 32'h80, 32'h0);

      // Edge on the same edge as the ack: set wins, no overflow
      irq_raw[7] = 1'b1;
      repeat (5) tick();
      int_ack = 1'b1; ack_id = 6'd7;
      tick();
      int_ack = 1'b0; ack_id = ID_NONE;
      chk("simul_pend", pend & 32'h80, 32'h80);
      chk("simul_ovf", ovf & 32'h80, 32'h0);
      ack(6'd7);
      chk("ack7", pend & 32'h80, 32'h0);
      irq_raw[7] = 1'b0;

      // Polarity inversion on line 3 (level)
      cfg(CFG_SEL_EN, 32'hA9);
      cfg(CFG_SEL_POL, 32'h8);
      repeat (2) tick();
      chk("pol_filt", irq & 32'h8, 32'h0);
      repeat (6) tick();
      chk("pol_on", irq & 32'h8, 32'h8);
      irq_raw[3] = 1'b1;
      repeat (8) tick();
      chk("pol_off", irq & 32'h8, 32'h0);

      // Reset mid-operation
      repeat (4) tick();
      irq_raw[5] = 1'b1; irq_raw[7] = 1'b1;
      repeat (6) tick();
      chk("pend_a0", pend & 32'hA0, 32'hA0);
      irq_raw[0] = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_pend", pend, 32'h0);
      chk("midrst_ovf", ovf, 32'h0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("midrst_irq", irq, 32'h0);
      end

      // Randomized traffic against the model
      cfg(CFG_SEL_EN, $urandom);
      cfg(CFG_SEL_MODE, $urandom);
      for (int c = 0; c < 3000; c++) begin
         irq_raw = irq_raw ^ ($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) begin
            cfg_we = 1'b1;
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_wdata = $urandom;
         end else begin
            cfg_we = 1'b0;
         end
         int_ack = ($urandom_range(0, 3) == 0);
         ack_id = ($urandom_range(0, 7) == 0) ? ID_NONE
                : 6'($urandom_range(0, 33));
         tick();
      end
      cfg_we = 1'b0; int_ack = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/irq_conditioner.md
Name: irq_conditioner

Overview:
Front-end stage that conditions raw external interrupt lines before they reach the fixed-priority PIC's irq[31:0] input. Per line it provides:
- synchronisation into clk
- configurable polarity
- glitch filtering
- level or edge trigger, with an edge-pending latch cleared by the PIC acknowledge (int_ack plus the acknowledged int_id)
- enable masking

Output irq drives the PIC irq bus directly.

Parameters:
NUM_IRQ, 32, number of interrupt lines (1..32)
SYNC_STAGES, 2, synchroniser depth (>=2)
FILT_CYCLES, 3, consecutive stable cycles required before the filtered value changes (0 = bypass, max 15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
irq_raw  in  NUM_IRQ  asynchronous raw interrupt inputs
cfg_we  in  1  config write strobe, single cycle
cfg_sel  in  2  config target: 0 mode, 1 polarity, 2 enable, 3 overflow W1C
cfg_wdata  in  32  config write data, bit i maps to line i
int_ack  in  1  acknowledge pulse from CPU, same signal the PIC receives
ack_id  in  6  interrupt ID being acknowledged (PIC int_id)
irq  out  NUM_IRQ  conditioned requests to PIC
pend  out  NUM_IRQ  raw pending/level state before enable masking (status readback)
ovf  out  NUM_IRQ  sticky edge-overflow flags

Behaviour:
Reset:
- Clock and reset: single clock domain on clk; reset is synchronous and active-high.
- While reset is high at a clk edge, all state clears to 0: sync chains, filter state and counters, mode (all level), polarity (all active-high), enable (all disabled), pend, ovf, irq.
- Reset takes priority over cfg_we and int_ack in the same cycle.

Input path, per line i:
- Sync: SYNC_STAGES flops.
- Polarity: asserted_i = sync_out_i XOR pol[i].
- Filter: filt_i is a registered filtered value. When asserted_i differs from filt_i, a counter increments; when they are equal, the counter clears.
- filt_i toggles on the edge where the input has differed for FILT_CYCLES consecutive cycles, and the counter then clears.
- A single-cycle disagreement never propagates when FILT_CYCLES >= 2.
- FILT_CYCLES=0: filt_i = asserted_i, registered once.

Trigger:
- prev_i registers filt_i every cycle, in both modes.
- Edge mode (mode[i]=1): a rising edge of filt_i (filt_i & !prev_i) sets pend[i].
  - Clear: int_ack=1 with ack_id==i clears pend[i].
  - Set and clear in the same cycle: set wins, pend stays 1, ovf unaffected.
  - Overflow: an edge while pend[i] is already 1 and not being cleared sets ovf[i].
- Level mode (mode[i]=0): pend[i] <= filt_i each cycle. int_ack is ignored for the line and ovf is never set.
- ack_id >= NUM_IRQ (including 6'h3F "none") is ignored.

Enable and output:
- While en[i]=0, pend[i] is forced to 0 and edges are discarded.
- irq = pend & en, combinational from registers.

Latency:
- Raw change to irq change, for FILT_CYCLES >= 1: SYNC_STAGES + FILT_CYCLES + 1 clk edges. Default = 6.
- For FILT_CYCLES = 0: SYNC_STAGES + 2.
- Clear-by-ack: irq drops on the edge that samples int_ack.

Configuration:
- cfg_we writes take effect on the next edge and apply to bits [NUM_IRQ-1:0] only.
- sel 3 clears ovf bits where wdata=1. If a new overflow coincides, set wins.
- A mode write from edge to level or level to edge clears pend for each line whose mode changes, except where the result is level mode, in which case pend reloads filt next cycle.
- Switching to edge mode while the line is high produces no edge.
- A polarity write may toggle asserted_i; this is treated as a normal input change and passes through the filter.

Decomposition:
- Package irq_cond_pkg:
  - CFG_SEL_MODE=2'd0, CFG_SEL_POL=2'd1, CFG_SEL_EN=2'd2, CFG_SEL_OVF=2'd3
  - NUM_IRQ_MAX=32
  - ID_NONE=6'h3F
  - function filt_w(FILT_CYCLES) returning the counter width
- Sub-module irq_line_filter: one line's synchroniser, polarity XOR and glitch filter, outputting filt_i. Instantiated NUM_IRQ times in a generate loop.
- The top level holds the config registers, trigger/pending/overflow logic and output masking.

Test Plan:
1. Reset: hold reset 2 cycles with irq_raw=32'hFFFFFFFF -> irq=0, pend=0, ovf=0. After release with en=0, irq stays 0.
2. Level path: en=32'h1, mode=0, raw[0] rises at cycle 0 -> irq[0]=1 after exactly 6 edges. Raw falls -> irq[0]=0 6 edges later. A 1-cycle raw pulse -> irq[0] never asserts.
3. Edge and ack: mode[5]=1, en[5]=1, 10-cycle pulse on raw[5] -> irq[5] latches and stays 1 after the raw line falls. int_ack=1 with ack_id=5 -> irq[5]=0 next edge. int_ack=1 with ack_id=6'h3F -> no change.
4. Overflow and simultaneity:
   - Two filtered edges on line 7 with no ack between -> ovf[7]=1.
   - cfg_sel=3 with wdata=32'h80 -> ovf[7]=0.
   - Edge arriving on the same cycle as the ack for line 7 -> pend[7] remains 1 and ovf[7] stays 0.
5. Polarity: pol[3]=1, raw[3]=0 held, level mode, en[3]=1 -> irq[3]=1 after filter latency. Raw[3]=1 -> irq[3]=0.
6. Reset mid-operation: pend=32'h0000_00A0 with edge activity in flight, assert reset 1 cycle -> next edge pend=0, en=0, mode=0. A raw pulse in flight produces no irq.
